// File: rtl/micro_uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through read side, sticky overflow and registered IRQ.
// Optional character-timeout IRQ is enabled by defining MICRO_UART_RX_TIMEOUT_EN.
module micro_uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned TIMEOUT_CLKS = 640
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    input  logic [DEPTH_LOG2:0]   threshold,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  rx_timeout,
    output logic                  irq
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;

    logic [DATA_W-1:0] mem_q [Depth];
    ptr_t              wr_ptr_q, rd_ptr_q;
    ptr_t              level_next;
    logic              push, pop, drop;
    logic              overflow_q, overflow_d;
    logic              timeout_d;
    logic              irq_q, irq_d;

    // Extra pointer bit distinguishes full from empty.
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == ptr_t'(Depth));

    // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
    assign pop  = rd_en && !empty;
    assign push = rx_valid && (!full || rd_en);
    assign drop = rx_valid && full && !rd_en;

    assign level_next = level + ptr_t'(push) - ptr_t'(pop);
    assign rd_data    = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign overflow_d = drop || (overflow_q && !clr_overflow);
    assign overflow   = overflow_q;

    assign irq_d = ((threshold != '0) && (level_next >= threshold)) || overflow_d || timeout_d;
    assign irq   = irq_q;

`ifdef MICRO_UART_RX_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (push || pop || empty) begin
            idle_d = '0;
        end else if (idle_q != 16'(TIMEOUT_CLKS)) begin
            idle_d = idle_q + 16'd1;
        end
    end

    assign rx_timeout = (idle_q == 16'(TIMEOUT_CLKS));
    assign timeout_d  = (idle_d == 16'(TIMEOUT_CLKS));

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign rx_timeout = 1'b0;
    assign timeout_d  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_micro_uart_rx_fifo.sv
// Bench for micro_uart_rx_fifo: directed scenarios then random traffic against a queue model.
// Timeout expectations follow MICRO_UART_RX_TIMEOUT_EN.
module tb_micro_uart_rx_fifo;

    localparam int DL    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TMO   = 640;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [DL:0]   level;
    logic [DL:0]   threshold;
    logic          overflow;
    logic          clr_overflow;
    logic          rx_timeout;
    logic          irq;

    always #5 clk = ~clk;

    micro_uart_rx_fifo #(
        .DEPTH_LOG2  (DL),
        .DATA_W      (DW),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .threshold   (threshold),
        .overflow    (overflow),
        .clr_overflow(clr_overflow),
        .rx_timeout  (rx_timeout),
        .irq         (irq)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: stored bytes, sticky overflow, cycles since data last moved, irq.
    logic [DW-1:0] q[$];
    bit            ovf_m;
    int            idle_m;
    bit            irq_m;

    function automatic bit model_timeout();
`ifdef MICRO_UART_RX_TIMEOUT_EN
        return (q.size() != 0) && (idle_m >= TMO);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        check({tag, ".level"}, 32'(level), 32'(q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(head));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
        check({tag, ".rx_timeout"}, 32'(rx_timeout), 32'(model_timeout()));
        check({tag, ".irq"}, 32'(irq), 32'(irq_m));
    endtask

    task automatic step(input string tag, input bit rv, input bit rd, input bit clr,
                        input logic [DW-1:0] d);
        bit was_empty, was_full, did_pop, did_push, dropped;
        rx_valid     = rv;
        rd_en        = rd;
        clr_overflow = clr;
        rx_data      = d;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        did_pop   = rd && !was_empty;
        did_push  = rv && (!was_full || rd);
        dropped   = rv && was_full && !rd;
        if (did_pop) void'(q.pop_front());
        if (did_push) q.push_back(d);
        ovf_m  = dropped || (ovf_m && !clr);
        idle_m = (did_pop || did_push || was_empty) ? 0 : idle_m + 1;
        irq_m  = ((threshold != 0) && (q.size() >= int'(threshold))) || ovf_m || model_timeout();
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        ovf_m  = 1'b0;
        idle_m = 0;
        irq_m  = 1'b0;
        check_all("reset");
    endtask

    initial begin
        reset        = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = '0;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        threshold    = '0;
        do_reset();

        // Basic push/pop ordering.
        step("t1_push", 1, 0, 0, 8'h81);
        step("t1_push", 1, 0, 0, 8'h7E);
        step("t1_push", 1, 0, 0, 8'hFF);
        check("t1_level3", 32'(level), 32'd3);
        check("t1_head0", 32'(rd_data), 32'h81);
        step("t1_pop", 0, 1, 0, 8'h00);
        check("t1_head1", 32'(rd_data), 32'h7E);
        step("t1_pop", 0, 1, 0, 8'h00);
        check("t1_head2", 32'(rd_data), 32'hFF);
        step("t1_pop", 0, 1, 0, 8'h00);
        check("t1_empty_data", 32'(rd_data), 32'h00);

        // Overflow: 17th byte lost, sticky flag, clear strobe.
        for (int i = 0; i < 17; i++) step("t2_push", 1, 0, 0, 8'(i));
        check("t2_full", 32'(full), 32'd1);
        check("t2_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("t2_order", 32'(rd_data), 32'(i));
            step("t2_pop", 0, 1, 0, 8'h00);
        end
        step("t2_clr", 0, 0, 1, 8'h00);
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) step("t3_fill", 1, 0, 0, 8'(8'h20 + i));
        step("t3_both", 1, 1, 0, 8'hC3);
        check("t3_level", 32'(level), 32'd16);
        check("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) step("t3_pop", 0, 1, 0, 8'h00);
        check("t3_last", 32'(rd_data), 32'hC3);
        step("t3_pop", 0, 1, 0, 8'h00);

        // Level IRQ.
        threshold = 5'd4;
        for (int i = 1; i <= 3; i++) begin
            step("t4_push", 1, 0, 0, 8'(i));
            check("t4_irq_low", 32'(irq), 32'd0);
        end
        step("t4_push", 1, 0, 0, 8'd4);
        check("t4_irq_high", 32'(irq), 32'd1);
        step("t4_pop", 0, 1, 0, 8'h00);
        check("t4_irq_drop", 32'(irq), 32'd0);
        threshold = 5'd0;
        for (int i = 0; i < 13; i++) step("t4_thr0", 1, 0, 0, 8'(8'h40 + i));
        check("t4_thr0_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 16; i++) step("t4_drain", 0, 1, 0, 8'h00);

        // Reads on empty.
        step("t5_rd_empty", 0, 1, 0, 8'h00);
        check("t5_level0", 32'(level), 32'd0);
        step("t5_both_empty", 1, 1, 0, 8'hAA);
        check("t5_level1", 32'(level), 32'd1);
        check("t5_data", 32'(rd_data), 32'hAA);
        step("t5_pop", 0, 1, 0, 8'h00);

        // Character timeout.
        threshold = 5'd8;
        step("t6_push", 1, 0, 0, 8'h5A);
        for (int i = 0; i < TMO - 1; i++) step("t6_idle", 0, 0, 0, 8'h00);
        check("t6_tmo_early", 32'(rx_timeout), 32'd0);
        step("t6_idle", 0, 0, 0, 8'h00);
`ifdef MICRO_UART_RX_TIMEOUT_EN
        check("t6_tmo", 32'(rx_timeout), 32'd1);
        check("t6_irq", 32'(irq), 32'd1);
`else
        check("t6_tmo", 32'(rx_timeout), 32'd0);
        check("t6_irq", 32'(irq), 32'd0);
`endif
        step("t6_pop", 0, 1, 0, 8'h00);
        check("t6_tmo_clr", 32'(rx_timeout), 32'd0);
        check("t6_irq_clr", 32'(irq), 32'd0);

        // Reset mid-fill.
        threshold = 5'd0;
        for (int i = 0; i < 17; i++) step("t7_fill", 1, 0, 0, 8'(8'h90 + i));
        for (int i = 0; i < 11; i++) step("t7_pop", 0, 1, 0, 8'h00);
        check("t7_level5", 32'(level), 32'd5);
        check("t7_ovf", 32'(overflow), 32'd1);
        do_reset();
        check("t7_rst_empty", 32'(empty), 32'd1);
        check("t7_rst_data", 32'(rd_data), 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 31) == 0) threshold = 5'($urandom_range(0, 20));
            step("rand", ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 15) == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
